regfile_scoreboard: RTL and testbench

//  Parametrised successor to the core's integer register file. Adds N read ports,

---
 rtl/regfile_scoreboard_pkg.sv | 16 +
 rtl/regfile_scoreboard_rd.sv | 37 +++
 rtl/regfile_scoreboard.sv | 92 +++++++++
 tb/tb_regfile_scoreboard.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-file definitions: default sizes and ABI register indices.
// Imported by decode, issue, debug and the register file itself.
package regfile_scoreboard_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;

   localparam int ZERO = 0;
   localparam int RA   = 1;
   localparam int SP   = 2;
   localparam int HP   = 3;
   localparam int RC   = 4;
   localparam int T0   = 5;
   localparam int T6   = 31;

endpackage

// File: rtl/regfile_scoreboard_rd.sv
// One read port: register select, zero gate, write bypass and busy gating.
module rf_read_port
   import regfile_scoreboard_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREG     = NREG_DEF,
   parameter int AW       = $clog2(NREG),
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic [NREG-1:0][XLEN-1:0] regs,
   input  logic [NREG-1:0]           busy,
   input  logic [AW-1:0]             rd_addr,
   input  logic                      wr_en,
   input  logic [AW-1:0]             wr_addr,
   input  logic [XLEN-1:0]           wr_data,
   output logic [XLEN-1:0]           rd_data,
   output logic                      rd_busy
);

   logic is_zero;
   logic hit;

   always_comb begin
      is_zero = (ZERO_REG != 0) && (rd_addr == '0);
      hit     = (BYPASS != 0) && wr_en && (wr_addr == rd_addr) && !is_zero;
      rd_data = regs[rd_addr];
      rd_busy = busy[rd_addr] & ~hit;
      if (is_zero) begin
         rd_data = '0;
         rd_busy = 1'b0;
      end else if (hit) begin
         rd_data = wr_data;
      end
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with N read ports, write bypass, zero register
// and a busy scoreboard with an incrementally tracked pending-write count.
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREG     = NREG_DEF,
   parameter int AW       = $clog2(NREG),
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   output logic                iss_ok,
   input  logic                flush,
   output logic [NREG-1:0]     busy_vec,
   output logic [AW:0]         pend_cnt
);

   logic [NREG-1:0][XLEN-1:0] regs_q;
   logic [NREG-1:0]           busy_q;
   logic [NREG-1:0]           busy_d;
   logic [AW:0]               pend_q;
   logic [AW:0]               pend_d;
   logic                      wr_ok;
   logic                      iss_set;
   logic                      clr;

   always_comb begin
      wr_ok   = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
      iss_ok  = iss_en && !flush &&
                (!busy_q[iss_addr] || (wr_en && (wr_addr == iss_addr)));
      iss_set = iss_ok && !((ZERO_REG != 0) && (iss_addr == '0));
      clr     = wr_ok && busy_q[wr_addr];
      busy_d  = busy_q;
      if (wr_ok) busy_d[wr_addr] = 1'b0;
      // issue after write: a new producer wins over the retiring one
      if (iss_set) busy_d[iss_addr] = 1'b1;
      pend_d = pend_q + {{AW{1'b0}}, iss_set} - {{AW{1'b0}}, clr};
      if (flush) begin
         busy_d = '0;
         pend_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '0;
         busy_q <= '0;
         pend_q <= '0;
      end else begin
         if (wr_ok) regs_q[wr_addr] <= wr_data;
         busy_q <= busy_d;
         pend_q <= pend_d;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      rf_read_port #(
         .XLEN     (XLEN),
         .NREG     (NREG),
         .AW       (AW),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_rd (
         .regs    (regs_q),
         .busy    (busy_q),
         .rd_addr (rd_addr[i*AW +: AW]),
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .rd_data (rd_data[i*XLEN +: XLEN]),
         .rd_busy (rd_busy[i])
      );
   end

   assign busy_vec = busy_q;
   assign pend_cnt = pend_q;

   pend_inv: assert property (@(posedge clk) disable iff (reset)
      int'(pend_q) == $countones(busy_q));

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table on a 32x2 instance,
// random traffic against a behavioural model on a 16x3 instance.
module tb_regfile_scoreboard;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic        a_reset, a_wr_en, a_iss_en, a_iss_ok, a_flush;
   logic [9:0]  a_rd_addr;
   logic [63:0] a_rd_data;
   logic [1:0]  a_rd_busy;
   logic [4:0]  a_wr_addr, a_iss_addr;
   logic [31:0] a_wr_data, a_busy_vec;
   logic [5:0]  a_pend_cnt;

   logic        b_reset, b_wr_en, b_iss_en, b_iss_ok, b_flush;
   logic [11:0] b_rd_addr;
   logic [95:0] b_rd_data;
   logic [2:0]  b_rd_busy;
   logic [3:0]  b_wr_addr, b_iss_addr;
   logic [31:0] b_wr_data;
   logic [15:0] b_busy_vec;
   logic [4:0]  b_pend_cnt;

   regfile_scoreboard #(
      .XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)
   ) dut_a (
      .clk(clk), .reset(a_reset),
      .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
      .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
      .iss_en(a_iss_en), .iss_addr(a_iss_addr), .iss_ok(a_iss_ok),
      .flush(a_flush), .busy_vec(a_busy_vec), .pend_cnt(a_pend_cnt)
   );

   regfile_scoreboard #(
      .XLEN(32), .NREG(16), .NRD(3), .ZERO_REG(1), .BYPASS(1)
   ) dut_b (
      .clk(clk), .reset(b_reset),
      .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .iss_en(b_iss_en), .iss_addr(b_iss_addr), .iss_ok(b_iss_ok),
      .flush(b_flush), .busy_vec(b_busy_vec), .pend_cnt(b_pend_cnt)
   );

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        ie;
      logic [4:0]  ia;
      logic        fl;
      logic [4:0]  r0;
      logic [4:0]  r1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic        eb0;
      logic        eb1;
      logic        eok;
      logic [31:0] ebv;
      logic [5:0]  epc;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic idle_a();
      a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0;
      a_iss_en = 0; a_iss_addr = 0; a_flush = 0; a_rd_addr = 0;
   endtask

   task automatic idle_b();
      b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0;
      b_iss_en = 0; b_iss_addr = 0; b_flush = 0; b_rd_addr = 0;
   endtask

   logic [31:0] mreg [16];
   bit          mbusy[16];

   initial begin
      tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0,
                  32'hDEADBEEF, 0, 0, 0, 0, 32'h0, 0};
      tbl[1]  = '{0, 0, 0, 0, 0, 0, 5, 5,
                  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 32'h0, 0};
      tbl[2]  = '{1, 0, 32'h1234, 1, 0, 0, 0, 5,
                  0, 32'hDEADBEEF, 0, 0, 1, 32'h0, 0};
      tbl[3]  = '{0, 0, 0, 1, 10, 0, 0, 10,
                  0, 0, 0, 0, 1, 32'h0, 0};
      tbl[4]  = '{0, 0, 0, 1, 10, 0, 0, 10,
                  0, 0, 0, 1, 0, 32'h400, 1};
      tbl[5]  = '{1, 10, 32'hAA, 1, 10, 0, 0, 10,
                  0, 32'hAA, 0, 0, 1, 32'h400, 1};
      tbl[6]  = '{1, 10, 32'hAA, 1, 1, 0, 0, 10,
                  0, 32'hAA, 0, 0, 1, 32'h400, 1};
      tbl[7]  = '{0, 0, 0, 1, 2, 0, 0, 10,
                  0, 32'hAA, 0, 0, 1, 32'h002, 1};
      tbl[8]  = '{0, 0, 0, 1, 3, 0, 1, 0,
                  0, 0, 1, 0, 1, 32'h006, 2};
      tbl[9]  = '{1, 2, 32'h77, 1, 4, 1, 2, 3,
                  32'h77, 0, 0, 1, 0, 32'h00E, 3};
      tbl[10] = '{0, 0, 0, 1, 4, 0, 2, 3,
                  32'h77, 0, 0, 0, 1, 32'h0, 0};
      tbl[11] = '{0, 0, 0, 1, 7, 0, 5, 4,
                  32'hDEADBEEF, 0, 0, 1, 1, 32'h010, 1};

      a_reset = 1; b_reset = 1;
      idle_a(); idle_b();
      repeat (2) @(posedge clk);
      @(negedge clk);
      a_reset = 0; b_reset = 0;
      #1;
      chk("rst_busy", a_busy_vec, 0);
      chk("rst_pend", a_pend_cnt, 0);
      for (int i = 0; i < 32; i++) begin
         a_rd_addr = {5'(31 - i), 5'(i)};
         #1;
         chk($sformatf("rst_rd0_%0d", i), a_rd_data[31:0], 0);
         chk($sformatf("rst_rd1_%0d", i), a_rd_data[63:32], 0);
      end

      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         a_wr_en = tbl[k].we; a_wr_addr = tbl[k].wa; a_wr_data = tbl[k].wd;
         a_iss_en = tbl[k].ie; a_iss_addr = tbl[k].ia; a_flush = tbl[k].fl;
         a_rd_addr = {tbl[k].r1, tbl[k].r0};
         #1;
         chk($sformatf("v%0d_rd0", k), a_rd_data[31:0], tbl[k].e0);
         chk($sformatf("v%0d_rd1", k), a_rd_data[63:32], tbl[k].e1);
         chk($sformatf("v%0d_rb0", k), a_rd_busy[0], tbl[k].eb0);
         chk($sformatf("v%0d_rb1", k), a_rd_busy[1], tbl[k].eb1);
         chk($sformatf("v%0d_ok", k), a_iss_ok, tbl[k].eok);
         chk($sformatf("v%0d_bv", k), a_busy_vec, tbl[k].ebv);
         chk($sformatf("v%0d_pc", k), a_pend_cnt, tbl[k].epc);
      end

      @(negedge clk);
      idle_a();
      #1;
      chk("pre_rst_bv", a_busy_vec, 32'h90);
      chk("pre_rst_pc", a_pend_cnt, 2);

      a_reset = 1;
      a_wr_en = 1; a_wr_addr = 4; a_wr_data = 32'h5;
      a_iss_en = 1; a_iss_addr = 9;
      @(negedge clk);
      a_reset = 0;
      idle_a();
      a_rd_addr = {5'd10, 5'd5};
      #1;
      chk("mid_rst_bv", a_busy_vec, 0);
      chk("mid_rst_pc", a_pend_cnt, 0);
      chk("mid_rst_r5", a_rd_data[31:0], 0);
      chk("mid_rst_r10", a_rd_data[63:32], 0);
      a_rd_addr = {5'd2, 5'd4};
      #1;
      chk("mid_rst_r4", a_rd_data[31:0], 0);
      chk("mid_rst_r2", a_rd_data[63:32], 0);

      for (int r = 0; r < 16; r++) begin
         mreg[r] = 0;
         mbusy[r] = 0;
      end
      for (int c = 0; c < 3000; c++) begin
         logic [3:0]  ra[3];
         logic [15:0] mv;
         logic        eok;
         int          cnt;
         @(negedge clk);
         b_reset    = ($urandom_range(0, 99) == 0);
         b_wr_en    = 1'($urandom_range(0, 1));
         b_wr_addr  = 4'($urandom_range(0, 15));
         b_wr_data  = $urandom;
         b_iss_en   = ($urandom_range(0, 2) != 0);
         b_iss_addr = 4'($urandom_range(0, 15));
         b_flush    = ($urandom_range(0, 19) == 0);
         for (int p = 0; p < 3; p++) ra[p] = 4'($urandom_range(0, 15));
         b_rd_addr = {ra[2], ra[1], ra[0]};
         #1;
         for (int p = 0; p < 3; p++) begin
            logic [31:0] ed;
            logic        eb;
            if (ra[p] == 0) begin
               ed = 0; eb = 0;
            end else if (b_wr_en && b_wr_addr == ra[p]) begin
               ed = b_wr_data; eb = 0;
            end else begin
               ed = mreg[ra[p]]; eb = mbusy[ra[p]];
            end
            chk($sformatf("rnd%0d_rd%0d", c, p), b_rd_data[p*32 +: 32], ed);
            chk($sformatf("rnd%0d_rb%0d", c, p), b_rd_busy[p], eb);
         end
         eok = b_iss_en && !b_flush &&
               (!mbusy[b_iss_addr] || (b_wr_en && b_wr_addr == b_iss_addr));
         mv = 0; cnt = 0;
         for (int r = 0; r < 16; r++) begin
            mv[r] = mbusy[r];
            if (mbusy[r]) cnt++;
         end
         chk($sformatf("rnd%0d_ok", c), b_iss_ok, eok);
         chk($sformatf("rnd%0d_bv", c), b_busy_vec, mv);
         chk($sformatf("rnd%0d_pc", c), b_pend_cnt, cnt);
         if (b_reset) begin
            for (int r = 0; r < 16; r++) begin
               mreg[r] = 0;
               mbusy[r] = 0;
            end
         end else begin
            if (b_wr_en && b_wr_addr != 0) begin
               mreg[b_wr_addr] = b_wr_data;
               mbusy[b_wr_addr] = 0;
            end
            if (eok && b_iss_addr != 0) mbusy[b_iss_addr] = 1;
            if (b_flush)
               for (int r = 0; r < 16; r++) mbusy[r] = 0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
